// File: rtl/sensor_display_scheduler_pkg.sv
// sensor_sched_pkg
//   Shared types and constants for the sensor display scheduler:
//   - the scheduler FSM state enum (IDLE / START / WAIT)
//   - the width of the measurement values and of the failure counter
//   - a saturating increment used by the failure counter
package sensor_sched_pkg;

  localparam int VAL_W = 16;
  localparam int ERR_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    logic [ERR_W-1:0] r;
    if (v == {ERR_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(ERR_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/sensor_display_scheduler_tick_gen.sv
// tick_gen
//   Free-running period timer. The counter idles at 0 out of reset, so the
//   first tick appears in the first cycle after reset is released; after
//   that a tick fires once every PERIOD_CYC cycles.
// Ports:
//   clk_pix  in   pixel clock
//   rst_pix  in   synchronous active-high reset
//   tick     out  high for one cycle whenever the counter is 0
module tick_gen #(
  parameter int PERIOD_CYC = 37000000
) (
  input  logic clk_pix,
  input  logic rst_pix,
  output logic tick
);

  localparam int CW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam logic [CW-1:0] RELOAD  = CW'(PERIOD_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] r_cnt;

  // Down-counter: reload on the tick cycle, otherwise decrement.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_cnt <= '0;
    end else if (r_cnt == '0) begin
      r_cnt <= RELOAD;
    end else begin
      r_cnt <= r_cnt - CNT_ONE;
    end
  end

  assign tick = (r_cnt == '0);

endmodule

// File: rtl/sensor_display_scheduler.sv
// sensor_display_scheduler
//   Periodically requests a temperature/pressure measurement, retries failed
//   attempts, and hands finished results to the text renderer only at frame
//   boundaries so the displayed digits never tear mid-frame.
// Ports:
//   clk_pix        in   pixel clock (only clock)
//   rst_pix        in   synchronous active-high reset
//   frame_start    in   pulse at the first pixel of each frame
//   meas_start     out  one-cycle request to the SPI engine
//   meas_busy      in   engine busy; requests are held off while high
//   meas_done      in   result pulse, meas_t/meas_p valid with it
//   meas_err       in   engine error pulse
//   meas_t/meas_p  in   raw results
//   t_value/p_value out frame-stable displayed values
//   stale          out  displayed values are not from the latest period
//   err_cnt        out  saturating count of failed periods
module sensor_display_scheduler
  import sensor_sched_pkg::*;
#(
  parameter int PERIOD_CYC  = 37000000,
  parameter int TIMEOUT_CYC = 2000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic             frame_start,
  output logic             meas_start,
  input  logic             meas_busy,
  input  logic             meas_done,
  input  logic             meas_err,
  input  logic [VAL_W-1:0] meas_t,
  input  logic [VAL_W-1:0] meas_p,
  output logic [VAL_W-1:0] t_value,
  output logic [VAL_W-1:0] p_value,
  output logic             stale,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
  // The attempt times out in its TIMEOUT_CYC-th WAIT cycle, i.e. when the
  // counter would step onto TIMEOUT_CYC.
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT_CYC - 1);
  localparam logic [WW-1:0] WAIT_ONE   = WW'(1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);
  localparam logic [RW-1:0] RETRY_ONE  = RW'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_tick;
  logic [WW-1:0]    r_wait_cnt;
  logic [RW-1:0]    r_retry;
  logic             r_pending;
  logic [VAL_W-1:0] r_pend_t;
  logic [VAL_W-1:0] r_pend_p;
  logic [VAL_W-1:0] r_t_value;
  logic [VAL_W-1:0] r_p_value;
  logic             r_stale;
  logic [ERR_W-1:0] r_err_cnt;
  logic             w_meas_start;
  logic             w_capture;
  logic             w_fail;
  logic             w_retry;
  logic             w_attempt_bad;
  logic             w_show;

  tick_gen #(.PERIOD_CYC(PERIOD_CYC)) u_tick_gen (
    .clk_pix (clk_pix),
    .rst_pix (rst_pix),
    .tick    (w_tick)
  );

  // A simultaneous done+err is an error; done beats a same-cycle timeout.
  assign w_attempt_bad = meas_err | (~meas_done & (r_wait_cnt == WAIT_LAST));
  assign w_show        = frame_start & r_pending;

  // FSM state register.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and per-cycle actions.
  always_comb begin
    w_state_nxt  = r_state;
    w_meas_start = 1'b0;
    w_capture    = 1'b0;
    w_fail       = 1'b0;
    w_retry      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_tick) begin
          w_state_nxt = START;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: begin
        if (!meas_busy) begin
          w_meas_start = 1'b1;
          w_state_nxt  = WAIT;
        end else begin
          w_state_nxt = START;
        end
      end
      WAIT: begin
        if (meas_done && !meas_err) begin
          w_capture   = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_attempt_bad) begin
          if (r_retry == RETRY_LAST) begin
            w_fail      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_retry     = 1'b1;
            w_state_nxt = START;
          end
        end else begin
          w_state_nxt = WAIT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // WAIT cycle counter, cleared whenever the FSM is not waiting.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_wait_cnt <= '0;
    end else if (r_state == WAIT) begin
      r_wait_cnt <= r_wait_cnt + WAIT_ONE;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Retry counter: per-period attempt index, zero while idle.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_retry <= '0;
    end else if (w_retry) begin
      r_retry <= r_retry + RETRY_ONE;
    end else if (w_fail || (r_state == IDLE)) begin
      r_retry <= '0;
    end else begin
      r_retry <= r_retry;
    end
  end

  // Pending result buffer; a new capture wins over a same-cycle hand-off.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_pending <= 1'b0;
      r_pend_t  <= '0;
      r_pend_p  <= '0;
    end else if (w_capture) begin
      r_pending <= 1'b1;
      r_pend_t  <= meas_t;
      r_pend_p  <= meas_p;
    end else if (w_show) begin
      r_pending <= 1'b0;
      r_pend_t  <= r_pend_t;
      r_pend_p  <= r_pend_p;
    end else begin
      r_pending <= r_pending;
      r_pend_t  <= r_pend_t;
      r_pend_p  <= r_pend_p;
    end
  end

  // Displayed values change only at a frame boundary with a result waiting.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_t_value <= '0;
      r_p_value <= '0;
    end else if (w_show) begin
      r_t_value <= r_pend_t;
      r_p_value <= r_pend_p;
    end else begin
      r_t_value <= r_t_value;
      r_p_value <= r_p_value;
    end
  end

  // Stale flag and failure count; a failed period outranks a hand-off.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_stale   <= 1'b1;
      r_err_cnt <= '0;
    end else if (w_fail) begin
      r_stale   <= 1'b1;
      r_err_cnt <= sat_inc(r_err_cnt);
    end else if (w_show) begin
      r_stale   <= 1'b0;
      r_err_cnt <= r_err_cnt;
    end else begin
      r_stale   <= r_stale;
      r_err_cnt <= r_err_cnt;
    end
  end

  // The request must appear in the same cycle the engine is seen idle.
  assign meas_start = w_meas_start & ~rst_pix;
  assign t_value    = r_t_value;
  assign p_value    = r_p_value;
  assign stale      = r_stale;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_sensor_display_scheduler.sv
// Scoreboard bench for sensor_display_scheduler with PERIOD_CYC=100,
// TIMEOUT_CYC=20, MAX_RETRY=2. Each measurement period is planned up front
// (engine replies, busy windows, frame starts); the plan yields the expected
// meas_start cycles and display snapshots, which a negedge monitor compares.
module tb_sensor_display_scheduler;

  localparam int PER = 100;
  localparam int TMO = 20;
  localparam int MR  = 2;

  logic        clk_pix = 1'b0;
  logic        rst_pix = 1'b1;
  logic        frame_start = 1'b0;
  logic        meas_busy = 1'b0;
  logic        meas_done = 1'b0;
  logic        meas_err = 1'b0;
  logic [15:0] meas_t = 16'h0;
  logic [15:0] meas_p = 16'h0;
  logic        meas_start;
  logic [15:0] t_value;
  logic [15:0] p_value;
  logic        stale;
  logic [7:0]  err_cnt;

  sensor_display_scheduler #(
    .PERIOD_CYC  (PER),
    .TIMEOUT_CYC (TMO),
    .MAX_RETRY   (MR)
  ) dut (
    .clk_pix     (clk_pix),
    .rst_pix     (rst_pix),
    .frame_start (frame_start),
    .meas_start  (meas_start),
    .meas_busy   (meas_busy),
    .meas_done   (meas_done),
    .meas_err    (meas_err),
    .meas_t      (meas_t),
    .meas_p      (meas_p),
    .t_value     (t_value),
    .p_value     (p_value),
    .stale       (stale),
    .err_cnt     (err_cnt)
  );

  always #5 clk_pix = ~clk_pix;

  int cyc = 0;
  always @(posedge clk_pix) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int          c;
    logic [15:0] t;
    logic [15:0] p;
    logic        s;
    logic [7:0]  e;
  } snap_t;

  snap_t chk_q[$];
  int    start_q[$];

  // Planned stimulus and planned model events, keyed by absolute cycle.
  bit          fs_a[int];
  bit          done_a[int];
  bit          err_a[int];
  bit          busy_a[int];
  bit          cap_a[int];
  bit          fail_a[int];
  logic [15:0] dt_a[int];
  logic [15:0] dp_a[int];

  // Reference model of what the renderer should see.
  logic [15:0] m_t, m_p, m_pt, m_pp;
  bit          m_pend;
  logic        m_stale;
  logic [7:0]  m_err;

  task automatic model_reset();
    m_t = 16'h0; m_p = 16'h0; m_pt = 16'h0; m_pp = 16'h0;
    m_pend = 1'b0; m_stale = 1'b1; m_err = 8'h0;
  endtask

  task automatic push_snap(input int c);
    snap_t s;
    s.c = c; s.t = m_t; s.p = m_p; s.s = m_stale; s.e = m_err;
    chk_q.push_back(s);
  endtask

  // Drive one cycle from the plan and advance the model by that cycle.
  task automatic do_cycle(input bit r);
    int c;
    c = cyc;
    rst_pix     = r;
    frame_start = (fs_a.exists(c) != 0);
    meas_done   = (done_a.exists(c) != 0);
    meas_err    = (err_a.exists(c) != 0);
    meas_busy   = (busy_a.exists(c) != 0);
    meas_t      = (dt_a.exists(c) != 0) ? dt_a[c] : 16'h0;
    meas_p      = (dp_a.exists(c) != 0) ? dp_a[c] : 16'h0;
    if (r) begin
      model_reset();
    end else begin
      if ((fs_a.exists(c) != 0) && m_pend) begin
        m_t = m_pt; m_p = m_pp; m_stale = 1'b0; m_pend = 1'b0;
      end
      if (cap_a.exists(c) != 0) begin
        m_pt = dt_a[c]; m_pp = dp_a[c]; m_pend = 1'b1;
      end
      if (fail_a.exists(c) != 0) begin
        m_err   = (m_err == 8'hFF) ? m_err : m_err + 8'd1;
        m_stale = 1'b1;
      end
      if (fs_a.exists(c) != 0) push_snap(c + 1);
    end
    @(posedge clk_pix);
    #1;
  endtask

  // Plan a period starting at tick cycle T.
  // kind: 0 random, 1 first-result, 2 all timeouts, 3 busy 30 + 0001/0002,
  //       4 same-cycle frame/done 0003/0004, 5 done+err then done, 6 forced fail
  task automatic plan_period(input int T, input int kind);
    int s, L, o, b, c, nfs;
    logic [15:0] vt, vp;
    if (kind == 3) b = 30;
    else if (kind == 0 && $urandom_range(0, 3) == 0) b = int'($urandom_range(1, 30));
    else b = 0;
    for (int i = 1; i <= b; i++) busy_a[T + i] = 1'b1;
    s = T + b + 1;
    for (int r = 0; r < MR; r++) begin
      start_q.push_back(s);
      L = int'($urandom_range(1, TMO));
      case (kind)
        1: begin o = 0; L = 5; end
        2: o = 3;
        5: o = (r == 0) ? 2 : 0;
        6: o = int'($urandom_range(1, 3));
        0: begin o = int'($urandom_range(0, 5)); o = (o < 3) ? 0 : o - 2; end
        default: o = 0;
      endcase
      if (o == 3) L = TMO;
      c = s + L;
      if (o == 0) begin
        case (kind)
          1: begin vt = 16'h04D2; vp = 16'h162E; end
          3: begin vt = 16'h0001; vp = 16'h0002; end
          4: begin vt = 16'h0003; vp = 16'h0004; end
          default: begin vt = 16'($urandom_range(0, 65535)); vp = 16'($urandom_range(0, 65535)); end
        endcase
        done_a[c] = 1'b1; dt_a[c] = vt; dp_a[c] = vp; cap_a[c] = 1'b1;
        if (kind == 4) begin fs_a[c] = 1'b1; fs_a[c + 10] = 1'b1; end
        break;
      end
      if (o == 1 || o == 2) err_a[c] = 1'b1;
      if (o == 2) begin
        done_a[c] = 1'b1;
        dt_a[c] = 16'($urandom_range(0, 65535));
        dp_a[c] = 16'($urandom_range(0, 65535));
      end
      if (r == MR - 1) fail_a[c] = 1'b1;
      else s = c + 1;
    end
    if (kind == 1) begin
      fs_a[T + 20] = 1'b1;
    end else if (kind == 0 || kind == 5 || kind == 6) begin
      nfs = int'($urandom_range(0, 2));
      for (int i = 0; i < nfs; i++) begin
        c = T + int'($urandom_range(0, PER - 1));
        if (fail_a.exists(c) == 0) fs_a[c] = 1'b1;
      end
    end
    if ((kind == 0 || kind == 6) && $urandom_range(0, 2) == 0) begin
      c = T + int'($urandom_range(80, 95));
      if ($urandom_range(0, 1) == 1) begin
        done_a[c] = 1'b1;
        dt_a[c] = 16'($urandom_range(0, 65535));
        dp_a[c] = 16'($urandom_range(0, 65535));
      end else begin
        err_a[c] = 1'b1;
      end
    end
  endtask

  task automatic run_period(input int kind);
    plan_period(cyc, kind);
    for (int i = 0; i < PER; i++) begin
      if (i == PER - 1) push_snap(cyc);
      do_cycle(1'b0);
    end
  endtask

  // Monitor: request pulses and display snapshots against the scoreboard.
  always @(negedge clk_pix) begin
    if (meas_start === 1'b1) begin
      n_vec++;
      if (start_q.size() == 0) begin
        n_bad++;
        $display("FAIL meas_start_unexpected cyc=%0d got=1 want=0", cyc);
      end else begin
        int e;
        e = start_q.pop_front();
        if (e != cyc) begin
          n_bad++;
          $display("FAIL meas_start_cycle got=%0d want=%0d", cyc, e);
        end
      end
    end
    while (chk_q.size() > 0 && chk_q[0].c <= cyc) begin
      snap_t s;
      s = chk_q.pop_front();
      n_vec++;
      if (t_value !== s.t || p_value !== s.p || stale !== s.s || err_cnt !== s.e) begin
        n_bad++;
        $display("FAIL display cyc=%0d got t=%h p=%h stale=%0d err=%0d want t=%h p=%h stale=%0d err=%0d",
                 cyc, t_value, p_value, stale, err_cnt, s.t, s.p, s.s, s.e);
      end
    end
  end

  initial begin
    int T, E;
    model_reset();
    for (int i = 0; i < 3; i++) do_cycle(1'b1);
    push_snap(cyc);
    run_period(1);
    run_period(2);
    run_period(3);
    run_period(4);
    run_period(5);
    for (int i = 0; i < 20; i++) run_period(0);
    for (int i = 0; i < 300; i++) run_period(6);

    // Reset while waiting on the engine, then a late reply right after.
    T = cyc;
    start_q.push_back(T + 1);
    for (int i = 0; i < 5; i++) do_cycle(1'b0);
    do_cycle(1'b1);
    do_cycle(1'b1);
    E = cyc;
    done_a[E] = 1'b1; dt_a[E] = 16'hAAAA; dp_a[E] = 16'h5555;
    fs_a[E + 3] = 1'b1;
    push_snap(E);
    run_period(0);

    rst_pix = 1'b0; frame_start = 1'b0; meas_busy = 1'b0;
    meas_done = 1'b0; meas_err = 1'b0;
    @(negedge clk_pix);
    #1;
    n_vec++;
    if (start_q.size() != 0) begin
      n_bad++;
      $display("FAIL meas_start_missing got=%0d_left want=0_left", start_q.size());
    end
    n_vec++;
    if (chk_q.size() != 0) begin
      n_bad++;
      $display("FAIL display_unchecked got=%0d_left want=0_left", chk_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
